// File: rtl/gbe_mdio_ctrl.sv
// Clause-22 MDIO master: serialises preamble/header/turnaround/data for one PHY register access.
// Latency: RSP_VALID pulses N*2*MDC_HALF+1 cycles after accept (N = 65 with preamble, 33 without).
// Backpressure: CMD_READY is high only when idle; CMD_VALID while busy is ignored, not queued.
//
// Ports:
//   CLK, RST                  system clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY       command handshake; CMD_WRITE, CMD_PHYAD, CMD_REGAD, CMD_WDATA latched on accept
//   RSP_VALID                 one-cycle pulse at frame end; RSP_RDATA/RSP_ERR valid with it
//   BUSY                      frame in progress
//   MDC, MDIO_O, MDIO_OE      management clock and pad drive (pad tri-state lives at top level)
//   MDIO_I                    asynchronous pad input, synchronised internally
module gbe_mdio_ctrl #(
  parameter int MDC_HALF    = 25,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [4:0]  CMD_PHYAD,
  input  logic [4:0]  CMD_REGAD,
  input  logic [15:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_OE,
  input  logic        MDIO_I
);

  localparam int            HW    = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam logic [HW-1:0] HLAST = HW'(MDC_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_END
  } state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hcnt_q;
  logic           mdc_q;
  logic [4:0]     bcnt_q, bcnt_d;
  logic [31:0]    tx_q;
  logic           wr_q;
  logic           mdio_o_q, mdio_o_d;
  logic           mdio_oe_q, mdio_oe_d;
  logic [15:0]    rx_q, rdata_q;
  logic           err_q, rsp_err_q;
  logic           rsp_vld_q, rsp_vld_d;
  logic           sync1_q, sync2_q;
  logic           accept, half_done, bit_end, sample_pt, field_last, shift_tx;

  // Last bit index within each field.
  function automatic logic [4:0] field_last_idx(input state_t s);
    case (s)
      S_PRE:   field_last_idx = 5'd31;
      S_HDR:   field_last_idx = 5'd13;
      S_TA:    field_last_idx = 5'd1;
      S_DATA:  field_last_idx = 5'd15;
      default: field_last_idx = 5'd0;
    endcase
  endfunction

  assign accept     = (state_q == S_IDLE) && CMD_VALID;
  assign half_done  = (state_q != S_IDLE) && (hcnt_q == HLAST);
  // MDC falls at the end of each bit (next bit is driven); it rises mid-bit (input is sampled).
  assign bit_end    = half_done && mdc_q;
  assign sample_pt  = half_done && !mdc_q;
  assign field_last = (bcnt_q == field_last_idx(state_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the pad drive for the upcoming bit. tx_q[31] always holds the
  // bit currently on the wire during HDR/TA/DATA, so the next bit is tx_q[30].
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    rsp_vld_d = 1'b0;
    shift_tx  = 1'b0;
    if (accept) begin
      bcnt_d    = 5'd0;
      mdio_oe_d = 1'b1;
      if (PREAMBLE_EN) begin
        state_d  = S_PRE;
        mdio_o_d = 1'b1;
      end else begin
        state_d  = S_HDR;
        mdio_o_d = 1'b0;  // first ST bit
      end
    end else if (bit_end) begin
      bcnt_d = field_last ? 5'd0 : bcnt_q + 5'd1;
      case (state_q)
        S_PRE: begin
          if (field_last) begin
            state_d  = S_HDR;
            mdio_o_d = tx_q[31];
          end
        end
        S_HDR: begin
          shift_tx = 1'b1;
          mdio_o_d = tx_q[30];
          if (field_last) begin
            state_d   = S_TA;
            mdio_oe_d = wr_q;  // reads release the bus for turnaround and data
          end
        end
        S_TA: begin
          shift_tx = 1'b1;
          mdio_o_d = tx_q[30];
          if (field_last) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (field_last) begin
            state_d   = S_END;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
          end else begin
            shift_tx = 1'b1;
            mdio_o_d = tx_q[30];
          end
        end
        S_END: begin
          state_d   = S_IDLE;
          rsp_vld_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hcnt_q    <= '0;
      mdc_q     <= 1'b0;
      bcnt_q    <= 5'd0;
      tx_q      <= 32'd0;
      wr_q      <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
      rx_q      <= 16'd0;
      rdata_q   <= 16'd0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      sync1_q   <= MDIO_I;
      sync2_q   <= sync1_q;
      bcnt_q    <= bcnt_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
      rsp_vld_q <= rsp_vld_d;

      // MDC only runs inside a frame; each bit starts low with the counter at 0.
      if (state_q == S_IDLE) begin
        hcnt_q <= '0;
        mdc_q  <= 1'b0;
      end else if (half_done) begin
        hcnt_q <= '0;
        mdc_q  <= ~mdc_q;
      end else begin
        hcnt_q <= hcnt_q + HW'(1);
      end

      // Reads load ones into TA/DATA so MDIO_O idles high while the bus is released.
      if (accept) begin
        wr_q <= CMD_WRITE;
        tx_q <= {2'b01, (CMD_WRITE ? 2'b01 : 2'b10), CMD_PHYAD, CMD_REGAD,
                 (CMD_WRITE ? {2'b10, CMD_WDATA} : 18'h3FFFF)};
      end else if (shift_tx) begin
        tx_q <= {tx_q[30:0], 1'b1};
      end

      if (sample_pt && !wr_q) begin
        if (state_q == S_TA && bcnt_q == 5'd1) begin
          err_q <= sync2_q;  // nobody pulled the bus low: no PHY at this address
        end
        if (state_q == S_DATA) begin
          rx_q <= {rx_q[14:0], sync2_q};
        end
      end

      if (rsp_vld_d) begin
        if (!wr_q) begin
          rdata_q   <= rx_q;
          rsp_err_q <= err_q;
        end else begin
          rsp_err_q <= 1'b0;
        end
      end
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign MDC       = mdc_q;
  assign MDIO_O    = mdio_o_q;
  assign MDIO_OE   = mdio_oe_q;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_gbe_mdio_ctrl.sv
// Directed bench for gbe_mdio_ctrl: default instance (preamble, MDC_HALF=25) and a
// short-frame instance (no preamble, MDC_HALF=4). Bits are recorded on MDC rising
// edges; a simple PHY model drives MDIO_I for the next bit after each MDC rise.
module tb_gbe_mdio_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // default instance
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_phyad, cmd_regad;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;
  logic        mdio_i = 1'b1;

  // short-frame instance
  logic        cmd_valid2, cmd_ready2, cmd_write2;
  logic [4:0]  cmd_phyad2, cmd_regad2;
  logic [15:0] cmd_wdata2;
  logic        rsp_valid2, rsp_err2, busy2, mdc2, mdio_o2, mdio_oe2;
  logic [15:0] rsp_rdata2;

  gbe_mdio_ctrl #(.MDC_HALF(25), .PREAMBLE_EN(1'b1)) u_dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_PHYAD(cmd_phyad), .CMD_REGAD(cmd_regad), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .BUSY(busy), .MDC(mdc), .MDIO_O(mdio_o), .MDIO_OE(mdio_oe), .MDIO_I(mdio_i)
  );

  gbe_mdio_ctrl #(.MDC_HALF(4), .PREAMBLE_EN(1'b0)) u_dut2 (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(cmd_valid2), .CMD_READY(cmd_ready2), .CMD_WRITE(cmd_write2),
    .CMD_PHYAD(cmd_phyad2), .CMD_REGAD(cmd_regad2), .CMD_WDATA(cmd_wdata2),
    .RSP_VALID(rsp_valid2), .RSP_RDATA(rsp_rdata2), .RSP_ERR(rsp_err2),
    .BUSY(busy2), .MDC(mdc2), .MDIO_O(mdio_o2), .MDIO_OE(mdio_oe2), .MDIO_I(1'b1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / PHY model, default instance. Bit b lives at index 64-b (MSB-first).
  logic [64:0] cap_o, cap_oe;
  logic [64:0] phy_vec = '1;
  int          bidx = 0;
  int          rsp_cnt = 0;
  logic        mdc_prev = 1'b0;

  always @(negedge CLK) begin
    if (!busy) begin
      bidx = 0;
    end else if (mdc && !mdc_prev) begin
      if (bidx <= 64) begin
        cap_o[64-bidx]  = mdio_o;
        cap_oe[64-bidx] = mdio_oe;
      end
      bidx++;
    end
    if (bidx <= 64) mdio_i = phy_vec[64-bidx];
    else            mdio_i = 1'b1;
    mdc_prev = mdc;
    if (rsp_valid) rsp_cnt++;
  end

  // Monitor, short-frame instance.
  logic [32:0] cap2_o, cap2_oe;
  int          bidx2 = 0;
  int          rise2_cyc [2];
  logic        mdc2_prev = 1'b0;

  always @(negedge CLK) begin
    if (!busy2) begin
      bidx2 = 0;
    end else if (mdc2 && !mdc2_prev) begin
      if (bidx2 < 2) rise2_cyc[bidx2] = cyc;
      if (bidx2 <= 32) begin
        cap2_o[32-bidx2]  = mdio_o2;
        cap2_oe[32-bidx2] = mdio_oe2;
      end
      bidx2++;
    end
    mdc2_prev = mdc2;
  end

  int acc_cyc = 0;

  task automatic issue(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd);
    @(negedge CLK);
    cmd_write = w; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd;
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 0; n < 5000; n++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    if (lat < 0) check("rsp_timeout", 65'(0), 65'(1));
  endtask

  localparam logic [64:0] WR_OE = {64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
  localparam logic [64:0] RD_OE = {46'h3FFF_FFFF_FFFF, 19'h0};

  initial begin
    int lat, n0;
    bit hit;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phyad = '0; cmd_regad = '0; cmd_wdata = '0;
    cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_phyad2 = '0; cmd_regad2 = '0; cmd_wdata2 = '0;

    // reset state
    repeat (3) @(negedge CLK);
    check("rst_ready",  65'(cmd_ready), 65'(1));
    check("rst_busy",   65'(busy),      65'(0));
    check("rst_mdc",    65'(mdc),       65'(0));
    check("rst_mdio_o", 65'(mdio_o),    65'(1));
    check("rst_oe",     65'(mdio_oe),   65'(0));
    check("rst_rsp",    65'(rsp_valid), 65'(0));
    check("rst_rdata",  65'(rsp_rdata), 65'(0));
    check("rst_err",    65'(rsp_err),   65'(0));
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // write 0x1140 to PHY1/REG0; a different command is held on the bus from the
    // next cycle on: ignored mid-frame, accepted in the RSP_VALID cycle.
    cmd_write = 1'b1; cmd_phyad = 5'd1; cmd_regad = 5'd0; cmd_wdata = 16'h1140;
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    @(negedge CLK);
    cmd_phyad = 5'd31; cmd_regad = 5'd31; cmd_wdata = 16'hABCD;
    wait_rsp(lat);
    check("wrA_lat",    65'(lat),       65'(3251));
    check("wrA_err",    65'(rsp_err),   65'(0));
    check("wrA_rdata",  65'(rsp_rdata), 65'(0));
    check("wrA_mdc_lo", 65'(mdc),       65'(0));
    check("wrA_ready",  65'(cmd_ready), 65'(1));
    check("wrA_stream", cap_o, {32'hFFFF_FFFF, 14'b01_01_00001_00000, 2'b10, 16'h1140, 1'b1});
    check("wrA_oe",     cap_oe, WR_OE);
    acc_cyc = cyc;
    @(negedge CLK);
    check("wrB_accept", 65'(busy), 65'(1));
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("wrB_lat",    65'(lat), 65'(3251));
    check("wrB_stream", cap_o, {32'hFFFF_FFFF, 14'b01_01_11111_11111, 2'b10, 16'hABCD, 1'b1});
    check("wrB_oe",     cap_oe, WR_OE);

    // reset pulse in the DATA field of a write
    issue(1'b1, 5'd1, 5'd0, 16'h1140);
    hit = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge CLK);
      if (bidx >= 52) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_mid_reach", 65'(hit), 65'(1));
    RST = 1'b1;
    #1;
    check("rst_mid_mdc",   65'(mdc),       65'(0));
    check("rst_mid_oe",    65'(mdio_oe),   65'(0));
    check("rst_mid_ready", 65'(cmd_ready), 65'(1));
    check("rst_mid_busy",  65'(busy),      65'(0));
    @(negedge CLK);
    RST = 1'b0;
    n0 = rsp_cnt;
    repeat (3400) @(negedge CLK);
    check("rst_mid_norsp", 65'(rsp_cnt - n0), 65'(0));

    // read PHY1/REG2, PHY returns TA=Z(pulled high),0 and data 0x0141
    phy_vec = {32'hFFFF_FFFF, 14'h3FFF, 2'b10, 16'h0141, 1'b1};
    issue(1'b0, 5'd1, 5'd2, 16'h0000);
    wait_rsp(lat);
    check("rd_lat",   65'(lat),       65'(3251));
    check("rd_rdata", 65'(rsp_rdata), 65'(16'h0141));
    check("rd_err",   65'(rsp_err),   65'(0));
    check("rd_hdr",   65'(cap_o[64:19]), 65'({32'hFFFF_FFFF, 14'b01_10_00001_00010}));
    check("rd_oe",    cap_oe, RD_OE);

    // read with nobody answering
    phy_vec = '1;
    issue(1'b0, 5'd1, 5'd2, 16'h0000);
    wait_rsp(lat);
    check("nophy_rdata", 65'(rsp_rdata), 65'(16'hFFFF));
    check("nophy_err",   65'(rsp_err),   65'(1));

    // a write clears the error flag and leaves read data alone
    issue(1'b1, 5'd1, 5'd0, 16'h1140);
    wait_rsp(lat);
    check("wr2_rdata", 65'(rsp_rdata), 65'(16'hFFFF));
    check("wr2_err",   65'(rsp_err),   65'(0));

    // short frame: no preamble, MDC_HALF=4
    @(negedge CLK);
    cmd_write2 = 1'b1; cmd_phyad2 = 5'd1; cmd_regad2 = 5'd0; cmd_wdata2 = 16'h1140;
    cmd_valid2 = 1'b1;
    acc_cyc    = cyc;
    @(negedge CLK);
    cmd_valid2 = 1'b0;
    lat = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge CLK);
      if (rsp_valid2) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    check("s_lat",    65'(lat), 65'(265));
    check("s_period", 65'(rise2_cyc[1] - rise2_cyc[0]), 65'(8));
    check("s_stream", 65'(cap2_o), 65'({14'b01_01_00001_00000, 2'b10, 16'h1140, 1'b1}));
    check("s_oe",     65'(cap2_oe), 65'({32'hFFFF_FFFF, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "bench stuck");
  end

endmodule
